serial_w_gen: RTL and testbench
===============================

// Module: serial_w_gen
// PURPOSE
//  Serial bit-stream transmitter: accepts a parallel word plus length/repeat on a Start strobe and
//  drives it one bit per Clock onto serial line W (MSB-first), with W_Valid framing.
//  Stimulus/transmit end for the lab's single-input serial FSMs (w in, z out); sits between a
//  controller or bench and any serial recognizer.
// PARAMETERS
//  WIDTH       8  max word length in bits (>=2)
//  LEN_W       4  width of Len; must hold WIDTH (= clog2(WIDTH+1))
//  RPT_W       4  width of Repeat
//  GAP_CYCLES  2  idle cycles (W=0, W_Valid=0) between repetitions; 0 allowed
// PORTS
//  Clock    in   1        rising-edge clock
//  Resetn   in   1        asynchronous, active-low reset
//  Start    in   1        request; sampled only in IDLE
//  Abort    in   1        synchronous cancel; priority over Start
//  Data     in   WIDTH    word; low Len bits sent, bit Len-1 first
//  Len      in   LEN_W    bits per frame; 0 or >WIDTH means WIDTH
//  Repeat   in   RPT_W    extra repetitions (0 = send once)
//  W        out  1        serial data, 0 whenever W_Valid=0
//  W_Valid  out  1        high on each cycle W carries a bit
//  Busy     out  1        high in SHIFT and GAP
//  Done     out  1        one-cycle pulse after final bit of final repetition
// BEHAVIOUR
//  - Reset: Resetn=0 forces IDLE immediately; W, W_Valid, Busy, Done = 0; counters/regs cleared.
//  - States (2-bit): IDLE=0, SHIFT=1, GAP=2, DONE=3. Outputs Moore-decoded from state + shift MSB.
//  - IDLE: Start=1 & Abort=0 at edge k -> load hold=Data<<(WIDTH-Len_eff), shreg=hold,
//    bitcnt=Len_eff, rptcnt=Repeat; SHIFT. First bit on W in cycle k+1 (1-cycle latency).
//  - SHIFT: W=shreg[WIDTH-1], W_Valid=1. Each edge: shreg<<=1, bitcnt--. On last bit (bitcnt==1):
//    rptcnt==0 -> DONE; else rptcnt--, shreg=hold, bitcnt=Len_eff, and
//    GAP (GAP_CYCLES>0, gapcnt=GAP_CYCLES) or straight back to SHIFT (GAP_CYCLES=0, no bubble).
//  - GAP: W=0, W_Valid=0, Busy=1; gapcnt-- each edge; gapcnt==1 -> SHIFT.
//  - DONE: Done=1, Busy=0 for exactly one cycle -> IDLE. Start in DONE ignored (not queued).
//  - Start while Busy: ignored; Data/Len/Repeat changes mid-frame have no effect (hold reg).
//  - Abort=1 in SHIFT/GAP/DONE: next state IDLE, no Done pulse; W drops to 0 next cycle.
//  - Len_eff = (Len==0 || Len>WIDTH) ? WIDTH : Len. Len=1 gives single-cycle frames.
//  - Total cycles Start->Done = Len_eff*(Repeat+1) + Repeat*GAP_CYCLES + 1.
//  - Counters never wrap: bitcnt/gapcnt reloaded before reaching 0; rptcnt saturates at 0.
// STRUCTURE
//  - Shared package serial_pkg: state constants IDLE/SHIFT/GAP/DONE (2-bit), common to the
//    lab's serial FSMs and benches.
//  - One sub-module: piso_shreg (WIDTH-bit parallel-in/serial-out, load/shift enables, MSB out).
//  - Top: next-state always block, state register (async Resetn), bit/gap/repeat counters.
// TESTING (WIDTH=8, GAP_CYCLES=2; cycle 0 = Start edge)
//  - Data=8'hB2, Len=0, Repeat=0 -> W=1,0,1,1,0,0,1,0 in cycles 1-8, W_Valid=1 there; Done cycle 9.
//  - Data=8'h06, Len=3, Repeat=0 -> W=1,1,0 cycles 1-3; Done cycle 4; Busy=0 cycle 4 on.
//  - Data=8'h01, Len=2, Repeat=2 -> W_Valid pattern 11 00 11 00 11, W=0,1,-,-,0,1,-,-,0,1; Done cycle 11.
//  - Start again in cycle 3 with Data=8'hFF during first case -> stream unchanged, no second frame.
//  - Abort=1 in cycle 4 of first case -> W=W_Valid=0 from cycle 5, no Done; new Start accepted cycle 5.
//  - Resetn=0 mid-SHIFT (cycle 5) -> W, W_Valid, Busy, Done = 0 same cycle; stays IDLE after release.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the lab's serial FSMs and benches.
// State encoding is common to transmitters and recognizers.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } serial_state_e;

  localparam int SERIAL_STATE_W = 2;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in / serial-out shift register, MSB first.
// Load wins over shift when both are asserted.
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;

  // Load a new word or shift one place toward the MSB.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_w_gen.sv
// Serial bit-stream transmitter: word -> MSB-first bits on W.
// Frames may repeat with idle gaps; Done pulses at the end.
module serial_w_gen
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Data,
  input  logic [LEN_W-1:0] Len,
  input  logic [RPT_W-1:0] Repeat,
  output logic             W,
  output logic             W_Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int GAP_W =
    (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [LEN_W-1:0] WLEN = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] GLEN = GAP_W'(GAP_CYCLES);

  serial_state_e    state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bitcnt_q, bitcnt_d;
  logic [RPT_W-1:0] rptcnt_q, rptcnt_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;

  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_din;
  logic             sh_msb;
  logic [LEN_W-1:0] len_eff;

  assign len_eff =
    ((Len == '0) || (Len > WLEN)) ? WLEN : Len;

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_din),
    .msb_o   (sh_msb)
  );

  // Next-state, counter updates and shifter control.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    len_d    = len_q;
    bitcnt_d = bitcnt_q;
    rptcnt_d = rptcnt_q;
    gapcnt_d = gapcnt_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = hold_q;
    unique case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          hold_d   = Data << (WLEN - len_eff);
          len_d    = len_eff;
          bitcnt_d = len_eff;
          rptcnt_d = Repeat;
          sh_din   = hold_d;
          sh_load  = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (bitcnt_q == LEN_W'(1)) begin
          if (rptcnt_q == '0) begin
            state_d = DONE;
          end else begin
            rptcnt_d = rptcnt_q - RPT_W'(1);
            bitcnt_d = len_q;
            sh_load  = 1'b1;
            if (GAP_CYCLES > 0) begin
              gapcnt_d = GLEN;
              state_d  = GAP;
            end else begin
              state_d  = SHIFT;
            end
          end
        end else begin
          sh_shift = 1'b1;
          bitcnt_d = bitcnt_q - LEN_W'(1);
        end
      end
      GAP: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (gapcnt_q == GAP_W'(1)) begin
          state_d = SHIFT;
        end else begin
          gapcnt_d = gapcnt_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame hold register and bit/gap/repeat counters.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hold_q   <= '0;
      len_q    <= '0;
      bitcnt_q <= '0;
      rptcnt_q <= '0;
      gapcnt_q <= '0;
    end else begin
      hold_q   <= hold_d;
      len_q    <= len_d;
      bitcnt_q <= bitcnt_d;
      rptcnt_q <= rptcnt_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  assign W_Valid = (state_q == SHIFT);
  assign W       = W_Valid & sh_msb;
  assign Busy    = (state_q == SHIFT) || (state_q == GAP);
  assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_serial_w_gen.sv
// Directed bench for serial_w_gen (WIDTH=8, GAP_CYCLES=2).
// Samples outputs 1 time unit after each rising edge.
module tb_serial_w_gen;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic       Abort;
  logic [7:0] Data;
  logic [3:0] Len;
  logic [3:0] Repeat;
  logic       W;
  logic       W_Valid;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  serial_w_gen #(
    .WIDTH      (8),
    .LEN_W      (4),
    .RPT_W      (4),
    .GAP_CYCLES (2)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Start   (Start),
    .Abort   (Abort),
    .Data    (Data),
    .Len     (Len),
    .Repeat  (Repeat),
    .W       (W),
    .W_Valid (W_Valid),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic obs,
                       input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    check({tag, " W"}, W, 1'b0);
    check({tag, " W_Valid"}, W_Valid, 1'b0);
    check({tag, " Busy"}, Busy, 1'b0);
    check({tag, " Done"}, Done, 1'b0);
  endtask

  // One frame, Repeat=0; bits holds the expected stream MSB-first.
  task automatic send_frame(input string tag,
                            input logic [7:0] d,
                            input logic [3:0] l,
                            input logic [7:0] bits,
                            input int n);
    Data = d; Len = l; Repeat = 4'd0; Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s W c%0d", tag, i + 1),
            W, bits[n-1-i]);
      check($sformatf("%s Vld c%0d", tag, i + 1),
            W_Valid, 1'b1);
      check($sformatf("%s Busy c%0d", tag, i + 1),
            Busy, 1'b1);
      check($sformatf("%s Done c%0d", tag, i + 1),
            Done, 1'b0);
      tick;
    end
    check({tag, " Done pulse"}, Done, 1'b1);
    check({tag, " Busy at Done"}, Busy, 1'b0);
    check({tag, " Vld at Done"}, W_Valid, 1'b0);
    tick;
    idle_outs({tag, " after"});
  endtask

  logic [9:0] vmask;
  logic [9:0] wexp;
  logic [7:0] b2;

  initial begin
    Resetn = 1'b0;
    Start  = 1'b0;
    Abort  = 1'b0;
    Data   = 8'h00;
    Len    = 4'd0;
    Repeat = 4'd0;
    #12;
    idle_outs("reset");
    @(negedge Clock);
    Resetn = 1'b1;
    tick;
    idle_outs("post reset");

    send_frame("b2_full", 8'hB2, 4'd0, 8'hB2, 8);
    send_frame("06_len3", 8'h06, 4'd3, 8'h06, 3);
    idle_outs("06 c5");
    send_frame("5a_len12", 8'h5A, 4'd12, 8'h5A, 8);
    send_frame("fe_len1", 8'hFE, 4'd1, 8'h00, 1);

    // Len=2, Repeat=2: 2 bits, 2 gap cycles, three times.
    vmask = 10'b1100110011;
    wexp  = 10'b0100010001;
    Data = 8'h01; Len = 4'd2; Repeat = 4'd2; Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rpt Vld c%0d", i + 1),
            W_Valid, vmask[9-i]);
      check($sformatf("rpt W c%0d", i + 1),
            W, wexp[9-i]);
      check($sformatf("rpt Busy c%0d", i + 1),
            Busy, 1'b1);
      check($sformatf("rpt Done c%0d", i + 1),
            Done, 1'b0);
      tick;
    end
    check("rpt Done c11", Done, 1'b1);
    check("rpt Busy c11", Busy, 1'b0);
    tick;
    idle_outs("rpt after");

    // Start during SHIFT with new Data is ignored.
    b2 = 8'hB2;
    Data = 8'hB2; Len = 4'd0; Repeat = 4'd0; Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        Start = 1'b1; Data = 8'hFF;
        Len = 4'd3; Repeat = 4'd5;
      end
      if (i == 5) Start = 1'b0;
      check($sformatf("busy_start W c%0d", i + 1),
            W, b2[7-i]);
      check($sformatf("busy_start Vld c%0d", i + 1),
            W_Valid, 1'b1);
      tick;
    end
    check("busy_start Done c9", Done, 1'b1);
    tick;
    idle_outs("busy_start c10");
    tick;
    idle_outs("busy_start c11");

    // Abort in cycle 4, then restart in cycle 5.
    Data = 8'hB2; Len = 4'd0; Repeat = 4'd0; Start = 1'b1;
    tick;
    Start = 1'b0;
    tick; tick; tick;
    check("abort W c4", W, 1'b1);
    check("abort Vld c4", W_Valid, 1'b1);
    Abort = 1'b1;
    tick;
    Abort = 1'b0;
    idle_outs("abort c5");
    Data = 8'h06; Len = 4'd3; Start = 1'b1;
    tick;
    Start = 1'b0;
    check("restart W c6", W, 1'b1);
    check("restart Vld c6", W_Valid, 1'b1);
    tick;
    check("restart W c7", W, 1'b1);
    tick;
    check("restart W c8", W, 1'b0);
    check("restart Vld c8", W_Valid, 1'b1);
    tick;
    check("restart Done c9", Done, 1'b1);
    tick;
    idle_outs("restart c10");

    // Asynchronous reset in the middle of SHIFT.
    Data = 8'hFF; Len = 4'd0; Repeat = 4'd3; Start = 1'b1;
    tick;
    Start = 1'b0;
    tick; tick; tick; tick;
    check("rst W c5 pre", W, 1'b1);
    check("rst Busy c5 pre", Busy, 1'b1);
    #2;
    Resetn = 1'b0;
    #1;
    idle_outs("rst asserted");
    @(negedge Clock);
    Resetn = 1'b1;
    tick;
    idle_outs("rst released 1");
    tick;
    idle_outs("rst released 2");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
